// File: rtl/mem_req_scheduler_if.sv
// Bus bundle between the request scheduler, its two requesters, the cache, the RAM
// and the response consumer. "master" is the scheduler side, "slave" the environment.
interface mem_req_scheduler_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req0_valid;
   logic          req0_mode;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req0_ready;

   logic          req1_valid;
   logic          req1_mode;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          req1_ready;

   logic          cache_start;
   logic [AW-1:0] cache_address;
   logic          cache_busy;
   logic [DW-1:0] cache_out;

   logic          ram_start;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic          ram_mode;
   logic          ram_busy;

   logic          rsp_valid;
   logic          rsp_id;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;

   modport master (
      input  req0_valid, req0_mode, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_mode, req1_addr, req1_data,
      output req1_ready,
      output cache_start, cache_address,
      input  cache_busy, cache_out,
      output ram_start, ram_address, ram_data, ram_mode,
      input  ram_busy,
      output rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      output req0_valid, req0_mode, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_mode, req1_addr, req1_data,
      input  req1_ready,
      input  cache_start, cache_address,
      output cache_busy, cache_out,
      input  ram_start, ram_address, ram_data, ram_mode,
      output ram_busy,
      input  rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/mem_req_scheduler.sv
// Round-robin scheduler for two requesters: reads go to the cache, writes to the RAM.
// One access in flight; start pulse, busy handshake, tagged response, watchdog abort.
module mem_req_scheduler #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic clk,
   input  logic rst,
   mem_req_scheduler_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

   state_t        state;
   logic          last_grant;
   logic [TW-1:0] wd_cnt;
   logic          lat_id;
   logic          lat_mode;

   logic          any_valid;
   logic          grant_id;
   logic          grant_mode;
   logic [AW-1:0] grant_addr;
   logic [DW-1:0] grant_data;
   logic          sel_busy;
   logic          wait_ok;
   logic          wait_err;

   // Tie goes to the requester that was not served last.
   always_comb begin
      // NOTE: default assignment first so every path drives grant_id and no latch is inferred.
      grant_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_id = ~last_grant;
      end else if (bus.req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign any_valid  = bus.req0_valid | bus.req1_valid;
   assign grant_mode = grant_id ? bus.req1_mode : bus.req0_mode;
   assign grant_addr = grant_id ? bus.req1_addr : bus.req0_addr;
   assign grant_data = grant_id ? bus.req1_data : bus.req0_data;

   // Only the unit that received the start pulse is watched.
   assign sel_busy = lat_mode ? bus.ram_busy : bus.cache_busy;

   // wd_cnt == 0 marks the grace cycle, where busy may not have risen yet.
   assign wait_ok  = (wd_cnt != '0) && !sel_busy;
   assign wait_err = !wait_ok && (wd_cnt == TIMEOUT_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         last_grant        <= 1'b1;
         wd_cnt            <= '0;
         lat_id            <= 1'b0;
         lat_mode          <= 1'b0;
         bus.req0_ready    <= 1'b0;
         bus.req1_ready    <= 1'b0;
         bus.cache_start   <= 1'b0;
         bus.cache_address <= '0;
         bus.ram_start     <= 1'b0;
         bus.ram_address   <= '0;
         bus.ram_data      <= '0;
         bus.ram_mode      <= 1'b0;
         bus.rsp_valid     <= 1'b0;
         bus.rsp_id        <= 1'b0;
         bus.rsp_data      <= '0;
         bus.rsp_err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
         bus.req0_ready  <= 1'b0;
         bus.req1_ready  <= 1'b0;
         bus.cache_start <= 1'b0;
         bus.ram_start   <= 1'b0;
         bus.rsp_valid   <= 1'b0;

         case (state)
            IDLE: begin
               if (any_valid) begin
                  lat_id     <= grant_id;
                  lat_mode   <= grant_mode;
                  last_grant <= grant_id;
                  state      <= ISSUE;
                  if (grant_id) begin
                     bus.req1_ready <= 1'b1;
                  end else begin
                     bus.req0_ready <= 1'b1;
                  end
                  // Pulses are registered here so they are high during ISSUE.
                  if (grant_mode) begin
                     bus.ram_start   <= 1'b1;
                     bus.ram_mode    <= 1'b1;
                     bus.ram_address <= grant_addr;
                     bus.ram_data    <= grant_data;
                  end else begin
                     bus.cache_start   <= 1'b1;
                     bus.cache_address <= grant_addr;
                  end
               end
            end

            ISSUE: begin
               wd_cnt <= '0;
               state  <= WAIT;
            end

            WAIT: begin
               wd_cnt <= wd_cnt + TW'(1);
               if (wait_ok || wait_err) begin
                  state         <= DONE;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_id    <= lat_id;
                  bus.rsp_err   <= wait_err;
                  bus.ram_mode  <= 1'b0;
                  bus.rsp_data  <= (wait_ok && !lat_mode) ? bus.cache_out : '0;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: behavioural cache/RAM models, expected grants and
// responses queued by the stimulus, checked by an independent monitor.
module tb_mem_req_scheduler;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      bit          id;
      bit          mode;
      logic [31:0] addr;
      logic [31:0] data;
   } grant_t;

   typedef struct {
      bit          id;
      logic [31:0] data;
      bit          err;
   } rsp_t;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;
   int   cyc;
   int   rdy_cyc;
   int   rsp_cyc;

   grant_t exp_grant[$];
   rsp_t   exp_rsp[$];
   grant_t g_mon;
   rsp_t   r_mon;

   mem_req_scheduler_if #(.AW(AW), .DW(DW)) bus ();

   mem_req_scheduler #(
      .AW(AW), .DW(DW), .TIMEOUT(5), .TW(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- cache / RAM models ----------------
   int                cache_lat, ram_lat;
   bit                cache_stuck, ram_stuck;
   bit                x_cache_busy, x_ram_busy;
   logic [31:0]       cache_mem [logic [31:0]];
   logic              c_busy_m, r_busy_m;
   int                c_cnt, r_cnt;
   logic [31:0]       c_rd;

   assign bus.cache_busy = c_busy_m | x_cache_busy;
   assign bus.ram_busy   = r_busy_m | x_ram_busy;

   always @(negedge clk) begin
      if (rst) begin
         c_busy_m = 1'b0;
         c_cnt    = 0;
      end else if (bus.cache_start) begin
         c_rd = cache_mem.exists(bus.cache_address) ? cache_mem[bus.cache_address] : 32'h0;
         if (cache_lat == 0 && !cache_stuck) begin
            c_busy_m      = 1'b0;
            bus.cache_out = c_rd;
         end else begin
            c_busy_m      = 1'b1;
            c_cnt         = (cache_lat > 0) ? cache_lat - 1 : 0;
            bus.cache_out = 32'hBAD0_BAD0;
         end
      end else if (c_busy_m && !cache_stuck) begin
         if (c_cnt == 0) begin
            c_busy_m      = 1'b0;
            bus.cache_out = c_rd;
         end else begin
            c_cnt--;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         r_busy_m = 1'b0;
         r_cnt    = 0;
      end else if (bus.ram_start) begin
         r_busy_m = (ram_lat != 0) || ram_stuck;
         r_cnt    = (ram_lat > 0) ? ram_lat - 1 : 0;
      end else if (r_busy_m && !ram_stuck) begin
         if (r_cnt == 0) r_busy_m = 1'b0;
         else r_cnt--;
      end
   end

   // ---------------- monitor ----------------
   logic p_r0, p_r1, p_rv;

   always @(negedge clk) begin
      if (rst) begin
         p_r0 = 1'b0;
         p_r1 = 1'b0;
         p_rv = 1'b0;
      end else begin
         if (bus.req0_ready || bus.req1_ready) begin
            rdy_cyc = cyc;
            check("ready_both", bus.req0_ready & bus.req1_ready, 0);
            check("ready_width", bus.req0_ready ? p_r0 : p_r1, 0);
            if (exp_grant.size() == 0) begin
               check("ready_unexpected", {bus.req0_ready, bus.req1_ready}, 0);
            end else begin
               g_mon = exp_grant.pop_front();
               check("grant_id", bus.req1_ready, g_mon.id);
               if (g_mon.mode) begin
                  check("ram_issue", {bus.ram_start, bus.ram_mode, bus.cache_start}, 3'b110);
                  check("ram_address", bus.ram_address, g_mon.addr);
                  check("ram_data", bus.ram_data, g_mon.data);
               end else begin
                  check("cache_issue", {bus.cache_start, bus.ram_start, bus.ram_mode}, 3'b100);
                  check("cache_address", bus.cache_address, g_mon.addr);
               end
            end
         end else if (bus.cache_start || bus.ram_start) begin
            check("start_without_ready", {bus.cache_start, bus.ram_start}, 2'b00);
         end

         if (bus.rsp_valid) begin
            rsp_cyc = cyc;
            check("rsp_width", p_rv, 0);
            check("ram_mode_in_done", bus.ram_mode, 0);
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
               r_mon = exp_rsp.pop_front();
               check("rsp_id", bus.rsp_id, r_mon.id);
               check("rsp_data", bus.rsp_data, r_mon.data);
               check("rsp_err", bus.rsp_err, r_mon.err);
            end
         end
         p_r0 = bus.req0_ready;
         p_r1 = bus.req1_ready;
         p_rv = bus.rsp_valid;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_exp(input bit id, input bit mode, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input bit err);
      grant_t g;
      rsp_t   r;
      g.id = id; g.mode = mode; g.addr = addr; g.data = data;
      r.id = id; r.data = rdata; r.err = err;
      exp_grant.push_back(g);
      exp_rsp.push_back(r);
   endtask

   task automatic drive_req(input bit id, input bit mode, input logic [31:0] addr,
                            input logic [31:0] data);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_mode = mode; bus.req1_addr = addr; bus.req1_data = data;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_mode = mode; bus.req0_addr = addr; bus.req0_data = data;
      end
   endtask

   task automatic drop_req(input bit id);
      if (id) bus.req1_valid = 1'b0;
      else bus.req0_valid = 1'b0;
   endtask

   task automatic wait_ready(input bit id);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = id ? bus.req1_ready : bus.req0_ready;
      end
      if (!ok) check("ready_timeout", ok, 1);
   endtask

   // Issues one request from the idle state; returns the cycle in which valid was first seen.
   task automatic do_req(input bit id, input bit mode, input logic [31:0] addr,
                         input logic [31:0] data, output int issue_cyc);
      @(negedge clk);
      drive_req(id, mode, addr, data);
      issue_cyc = cyc;
      wait_ready(id);
      drop_req(id);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && (exp_rsp.size() != 0 || exp_grant.size() != 0); i++) begin
         @(negedge clk);
      end
      if (exp_rsp.size() != 0 || exp_grant.size() != 0) begin
         check("drain_timeout", exp_rsp.size() + exp_grant.size(), 0);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {bus.req0_ready, bus.req1_ready, bus.cache_start, bus.cache_address,
                   bus.ram_start, bus.ram_address, bus.ram_data, bus.ram_mode,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}, '0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t0;
      pass_cnt = 0; total_cnt = 0; cyc = 0;
      rst = 1'b1;
      bus.req0_valid = 0; bus.req0_mode = 0; bus.req0_addr = 0; bus.req0_data = 0;
      bus.req1_valid = 0; bus.req1_mode = 0; bus.req1_addr = 0; bus.req1_data = 0;
      bus.cache_out = 0;
      cache_lat = 0; ram_lat = 0; cache_stuck = 0; ram_stuck = 0;
      x_cache_busy = 0; x_ram_busy = 0;
      cache_mem[32'h10]  = 32'hDEAD_BEEF;
      cache_mem[32'h100] = 32'h1111_0100;
      cache_mem[32'h104] = 32'h2222_0104;
      cache_mem[32'h30]  = 32'h1234_5678;
      cache_mem[32'h70]  = 32'h7070_7070;

      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single read, cache busy for several cycles
      cache_lat = 3;
      push_exp(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
      do_req(0, 0, 32'h10, 32'h0, t0);
      wait_drain();
      repeat (3) @(negedge clk);
      check("rsp_hold", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, {1'b0, 32'hDEAD_BEEF, 1'b0});

      // Single write
      ram_lat = 2;
      push_exp(1, 1, 32'h20, 32'h55, 32'h0, 0);
      do_req(1, 1, 32'h20, 32'h55, t0);
      wait_drain();

      // Contention: last grant was 1, so grants run 0,1,0,1
      cache_lat = 1; ram_lat = 1;
      push_exp(0, 0, 32'h100, 32'h0,  32'h1111_0100, 0);
      push_exp(1, 1, 32'h200, 32'h11, 32'h0, 0);
      push_exp(0, 0, 32'h104, 32'h0,  32'h2222_0104, 0);
      push_exp(1, 1, 32'h204, 32'h22, 32'h0, 0);
      @(negedge clk);
      fork
         begin
            drive_req(0, 0, 32'h100, 32'h0);
            wait_ready(0);
            drive_req(0, 0, 32'h104, 32'h0);
            wait_ready(0);
            drop_req(0);
         end
         begin
            drive_req(1, 1, 32'h200, 32'h11);
            wait_ready(1);
            drive_req(1, 1, 32'h204, 32'h22);
            wait_ready(1);
            drop_req(1);
         end
      join
      wait_drain();

      // Zero-latency read while the unselected RAM reports busy
      cache_lat = 0; x_ram_busy = 1;
      push_exp(0, 0, 32'h30, 32'h0, 32'h1234_5678, 0);
      do_req(0, 0, 32'h30, 32'h0, t0);
      wait_drain();
      check("read_ready_latency", rdy_cyc - t0, 1);
      check("read_rsp_latency", rsp_cyc - t0, 4);
      x_ram_busy = 0;

      // Zero-latency write while the unselected cache reports busy
      ram_lat = 0; x_cache_busy = 1;
      push_exp(1, 1, 32'h40, 32'h99, 32'h0, 0);
      do_req(1, 1, 32'h40, 32'h99, t0);
      wait_drain();
      check("write_rsp_latency", rsp_cyc - t0, 4);
      x_cache_busy = 0;

      // Stuck cache: watchdog fires after TIMEOUT counted WAIT cycles
      cache_lat = 1; cache_stuck = 1;
      push_exp(1, 0, 32'h50, 32'h0, 32'h0, 1);
      do_req(1, 0, 32'h50, 32'h0, t0);
      wait_drain();
      check("timeout_rsp_latency", rsp_cyc - t0, 8);
      cache_stuck = 0;
      repeat (3) @(negedge clk);
      cache_lat = 2;
      push_exp(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
      do_req(0, 0, 32'h10, 32'h0, t0);
      wait_drain();

      // Reset during WAIT of a write from req0 (leaves last_grant = 0 before reset)
      ram_lat = 1; ram_stuck = 1;
      begin
         grant_t g;
         g.id = 0; g.mode = 1; g.addr = 32'h60; g.data = 32'h77;
         exp_grant.push_back(g);
      end
      do_req(0, 1, 32'h60, 32'h77, t0);
      repeat (2) @(negedge clk);
      check("ram_mode_in_wait", bus.ram_mode, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_outputs_zero("reset_async");
      repeat (2) @(negedge clk);
      ram_stuck = 0;
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Tie after reset: req0 must win
      cache_lat = 1;
      push_exp(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
      push_exp(1, 0, 32'h70, 32'h0, 32'h7070_7070, 0);
      @(negedge clk);
      fork
         begin
            drive_req(0, 0, 32'h10, 32'h0);
            wait_ready(0);
            drop_req(0);
         end
         begin
            drive_req(1, 0, 32'h70, 32'h0);
            wait_ready(1);
            drop_req(1);
         end
      join
      wait_drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
